// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter and sequencer that shares one F_Mul between two requesters.
// One operation in flight at a time: IDLE -> ISSUE -> WAIT -> RESP, with a WAIT-state watchdog.
module fp_mul_arbiter #(
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_inf,
  output logic             rsp_err,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_en,
  input  logic [31:0]      mul_out,
  input  logic             mul_zero,
  input  logic             mul_inf,
  input  logic             mul_flag,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising CLK edge where valid and ready are both high.
  // valid never depends on ready; a request ready is only raised alongside its own valid, and
  // rsp_valid with all rsp_* fields stays stable until rsp_ready accepts it.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;
  logic [31:0]      result_q, result_d;
  logic             zero_q, zero_d;
  logic             inf_q, inf_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             grant;
  logic             accept;

  // A lone requester always wins; on a tie the one not served last wins.
  assign grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign req0_ready = (state_q == S_IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == S_IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    wait_cnt_d   = wait_cnt_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    result_d     = result_q;
    zero_d       = zero_q;
    inf_d        = inf_q;
    err_d        = err_q;
    op_count_d   = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mul_a_d = grant ? req1_a : req0_a;
          mul_b_d = grant ? req1_b : req0_b;
          id_d    = grant;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 16'd1;
        // A flag arriving on the timeout cycle still counts as a good result.
        if (mul_flag) begin
          result_d = mul_out;
          zero_d   = mul_zero;
          inf_d    = mul_inf;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          result_d = QNAN;
          zero_d   = 1'b0;
          inf_d    = 1'b0;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          last_grant_d = id_q;
          op_count_d   = op_count_q + CNT_W'(1);
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      wait_cnt_q   <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      inf_q        <= 1'b0;
      err_q        <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      wait_cnt_q   <= wait_cnt_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      inf_q        <= inf_d;
      err_q        <= err_d;
      op_count_q   <= op_count_d;
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_en     = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_inf    = inf_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != S_IDLE);
  assign op_count   = op_count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with an F_Mul stub driven from a hand-computed product table.
module tb_fp_mul_arbiter;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 16;
  localparam int RW      = 36;
  localparam int NV      = 7;

  logic             CLK;
  logic             RST;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_inf, rsp_err;
  logic [31:0]      rsp_result, mul_a, mul_b, mul_out;
  logic             mul_en, mul_zero, mul_inf, mul_flag;
  logic             busy;
  logic [CNT_W-1:0] op_count;
  logic [1:0]       dbg_state;

  fp_mul_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_inf(rsp_inf), .rsp_err(rsp_err),
    .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_out(mul_out),
    .mul_zero(mul_zero), .mul_inf(mul_inf), .mul_flag(mul_flag),
    .busy(busy), .op_count(op_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic        hang;
    int          delay;
    logic [31:0] res;
    logic        zero;
    logic        inf;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[NV];
  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;
  logic [RW-1:0] exp_q[$];

  // F_Mul stub
  logic stub_hang = 1'b0;
  logic stub_bad = 1'b0;
  logic force_flag = 1'b0;
  logic stub_flag = 1'b0;
  int   stub_delay = 0;
  int   en_cnt = 0;

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    model = {2'b00, 32'hDEAD_BEEF};
    for (int i = NV - 1; i >= 0; i--)
      if (vecs[i].a == a && vecs[i].b == b) model = {vecs[i].zero, vecs[i].inf, vecs[i].res};
  endfunction

  always @(negedge CLK) begin
    if (mul_en) en_cnt = en_cnt + 1;
    else en_cnt = 0;
    {mul_zero, mul_inf, mul_out} = model(mul_a, mul_b);
    if (stub_bad) mul_out = 32'h1234_5678;
    stub_flag = mul_en && !stub_hang && (en_cnt == stub_delay + 2);
  end
  assign mul_flag = force_flag | stub_flag;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // scoreboard: compares every accepted response with the head of exp_q
  always @(negedge CLK) begin
    #2;
    if (!RST && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", {rsp_id, rsp_result, rsp_zero, rsp_inf, rsp_err}, '0);
      else check("rsp_fields", {rsp_id, rsp_result, rsp_zero, rsp_inf, rsp_err}, exp_q.pop_front());
    end
  end

  // driver: one isolated operation from a table record
  task automatic run_vec(input vec_t v);
    int n;
    int lat;
    stub_hang  = v.hang;
    stub_delay = v.delay;
    @(negedge CLK);
    if (v.id) begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b;
    end else begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b;
    end
    #1;
    n = 0;
    while (!(v.id ? req1_ready : req0_ready) && n < 20) begin
      @(negedge CLK); #1; n++;
    end
    check("vec_grant", v.id ? req1_ready : req0_ready, 1'b1);
    check("vec_other_ready", v.id ? req0_ready : req1_ready, 1'b0);
    exp_q.push_back({v.id, v.res, v.zero, v.inf, v.err});
    @(negedge CLK);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      @(negedge CLK); #1; lat++;
    end
    check("vec_latency", lat, v.lat);
    @(negedge CLK); #1;
    exp_count++;
    check("vec_op_count", op_count, exp_count);
    check("vec_idle", {busy, rsp_valid}, 2'b00);
    check("vec_mul_a_hold", mul_a, v.a);
    check("vec_mul_b_hold", mul_b, v.b);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{1'b0, 32'h41B26666, 32'hBF000000, 1'b0, 0, 32'hC1326666, 1'b0, 1'b0, 1'b0, 3};
    vecs[1] = '{1'b1, 32'h7F800000, 32'h404CCCCC, 1'b0, 2, 32'h7F800000, 1'b0, 1'b1, 1'b0, 5};
    vecs[2] = '{1'b0, 32'h00000000, 32'h404CCCCC, 1'b0, 1, 32'h00000000, 1'b1, 1'b0, 1'b0, 4};
    vecs[3] = '{1'b0, 32'h40000000, 32'h40400000, 1'b0, 0, 32'h40C00000, 1'b0, 1'b0, 1'b0, 3};
    vecs[4] = '{1'b1, 32'hC0000000, 32'h3F000000, 1'b0, 0, 32'hBF800000, 1'b0, 1'b0, 1'b0, 3};
    vecs[5] = '{1'b1, 32'h3F800000, 32'h3F800000, 1'b1, 0, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 10};
    vecs[6] = '{1'b0, 32'h40000000, 32'h40400000, 1'b0, 7, 32'h40C00000, 1'b0, 1'b0, 1'b0, 10};

    RST = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_rsp", {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_inf, rsp_err}, '0);
    check("rst_mul_a", mul_a, '0);
    check("rst_mul_b", mul_b, '0);
    check("rst_ctrl", {mul_en, busy, dbg_state}, '0);
    check("rst_op_count", op_count, '0);
    @(negedge CLK);
    RST = 1'b0;

    // contention: both requesters valid continuously, grants alternate from 0
    @(negedge CLK);
    req0_valid = 1'b1; req0_a = vecs[3].a; req0_b = vecs[3].b;
    req1_valid = 1'b1; req1_a = vecs[4].a; req1_b = vecs[4].b;
    #1;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      while (!(req0_ready || req1_ready) && n < 20) begin
        @(negedge CLK); #1; n++;
      end
      check("cont_ready0", req0_ready, (k % 2) == 0);
      check("cont_ready1", req1_ready, (k % 2) == 1);
      if (k > 0) check("cont_gap", n, 4);
      exp_q.push_back((k % 2) == 1 ? {1'b1, 32'hBF800000, 3'b000} : {1'b0, 32'h40C00000, 3'b000});
      @(negedge CLK); #1;
      n = 1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    exp_count = 4;
    check("cont_op_count", op_count, exp_count);

    // flag and garbage result while idle must be ignored
    @(negedge CLK);
    force_flag = 1'b1; stub_bad = 1'b1;
    repeat (3) begin
      @(negedge CLK); #1;
      check("idle_flag_ignored", {busy, rsp_valid}, 2'b00);
    end
    force_flag = 1'b0; stub_bad = 1'b0;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // backpressure: response held for 10 cycles, late flag ignored
    stub_hang = 1'b0; stub_delay = 0;
    @(negedge CLK);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = vecs[0].a; req0_b = vecs[0].b;
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin
      @(negedge CLK); #1; n++;
    end
    check("bp_grant", req0_ready, 1'b1);
    exp_q.push_back({1'b0, 32'hC1326666, 3'b000});
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge CLK); #1; n++;
    end
    stub_bad = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      force_flag = (i == 3);
      #1;
      check("bp_hold", {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_inf, rsp_err}, {1'b1, 1'b0, 32'hC1326666, 3'b000});
      check("bp_req_ready", req0_ready, 1'b0);
      check("bp_busy", busy, 1'b1);
    end
    @(negedge CLK);
    force_flag = 1'b0; stub_bad = 1'b0;
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge CLK); #1;
    exp_count++;
    check("bp_release", {busy, rsp_valid}, 2'b00);
    check("bp_op_count", op_count, exp_count);
    repeat (2) @(negedge CLK);
    #1;
    check("bp_op_count_once", op_count, exp_count);

    // reset in WAIT: silent abort, requester 0 wins the next tie
    stub_hang = 1'b1;
    @(negedge CLK);
    req1_valid = 1'b1; req1_a = vecs[4].a; req1_b = vecs[4].b;
    #1;
    n = 0;
    while (!req1_ready && n < 20) begin
      @(negedge CLK); #1; n++;
    end
    check("rw_grant", req1_ready, 1'b1);
    @(negedge CLK);
    req1_valid = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("rw_in_wait", {dbg_state, mul_en}, 3'b101);
    #1;
    RST = 1'b1;
    #1;
    check("rw_rsp_zero", {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_inf, rsp_err}, '0);
    check("rw_mul_zero", {mul_en, mul_a}, '0);
    check("rw_ctrl_zero", {busy, dbg_state, op_count}, '0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    stub_hang = 1'b0;
    exp_count = 0;
    repeat (3) begin
      @(negedge CLK); #1;
      check("rw_no_rsp", {busy, rsp_valid}, 2'b00);
    end
    @(negedge CLK);
    req0_valid = 1'b1; req0_a = vecs[0].a; req0_b = vecs[0].b;
    req1_valid = 1'b1; req1_a = vecs[4].a; req1_b = vecs[4].b;
    #1;
    check("rw_tie_ready0", req0_ready, 1'b1);
    check("rw_tie_ready1", req1_ready, 1'b0);
    exp_q.push_back({1'b0, 32'hC1326666, 3'b000});
    @(negedge CLK);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    exp_count++;
    check("rw_op_count", op_count, exp_count);

    repeat (2) @(negedge CLK);
    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
Two-port round-robin arbiter and sequencer for the shared single-precision floating multiplier (F_Mul).
- Accepts operand pairs from two requesters over valid/ready handshakes.
- Drives the multiplier's A/B/EN inputs and waits for Flag_Mul, with a watchdog timeout.
- Returns the result, zero and infinity flags to the winning requester through one tagged response channel.
- Sits between the FP ALU front-end and the F_Mul instance.

Parameters:
TIMEOUT, 32, max WAIT cycles before an operation is aborted with an error response (legal range 2..65535)
CNT_W, 16, width of the completed-operation counter

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has an operand pair
req0_ready  out  1  requester 0 pair accepted this cycle
req0_a  in  32  requester 0 operand A (IEEE-754 single)
req0_b  in  32  requester 0 operand B
req1_valid  in  1  requester 1 has an operand pair
req1_ready  out  1  requester 1 pair accepted this cycle
req1_a  in  32  requester 1 operand A
req1_b  in  32  requester 1 operand B
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_id  out  1  requester that owns the response
rsp_result  out  32  product
rsp_zero  out  1  multiplier zero flag
rsp_inf  out  1  multiplier infinity flag
rsp_err  out  1  watchdog timeout occurred
mul_a  out  32  to F_Mul A
mul_b  out  32  to F_Mul B
mul_en  out  1  to F_Mul EN
mul_out  in  32  from F_Mul OUT_MUL
mul_zero  in  1  from F_Mul zero
mul_inf  in  1  from F_Mul infinity
mul_flag  in  1  from F_Mul Flag_Mul; result-valid indication
busy  out  1  state != IDLE
op_count  out  CNT_W  completed responses, wraps

Behaviour:
- Reset (asynchronous, RST=1):
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - Wait counter cleared.
  - All outputs 0: mul_a, mul_b, all rsp_* fields and op_count included.
- Reset asserted mid-operation aborts the operation silently; no response is produced.
- State machine IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant is combinational: if only one valid is high, grant that requester. If both are high, grant !last_grant.
  - reqN_ready = (state==IDLE) & grant==N, at most one ready high per cycle.
  - On handshake: latch a/b into mul_a/mul_b, latch id, go to ISSUE.
  - A requester may drop valid before handshake; nothing is committed.
- ISSUE (1 cycle): mul_en=1 with operands stable; wait counter cleared; go to WAIT.
- WAIT:
  - mul_en stays 1 and the counter increments each cycle.
  - mul_flag is sampled only in WAIT; any flag seen in IDLE, ISSUE or RESP is ignored.
  - mul_flag=1: register mul_out/mul_zero/mul_inf into rsp_*, rsp_err=0, go to RESP.
  - Otherwise, if counter==TIMEOUT-1: rsp_result=32'h7FC00000 (qNaN), rsp_zero=0, rsp_inf=0, rsp_err=1, go to RESP.
  - If mul_flag and timeout coincide, mul_flag wins (rsp_err=0).
- RESP:
  - mul_en=0, rsp_valid=1; rsp fields held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready: last_grant=rsp_id, op_count+=1 (wraps modulo 2^CNT_W, counts error responses too), rsp_valid drops next cycle, go to IDLE.
- No new request is accepted before the return to IDLE; the block holds one operation in flight.
- Minimum latency (flag on the first WAIT cycle):
  - Handshake at cycle 0, ISSUE at cycle 1, WAIT at cycle 2, rsp_valid high at cycle 3.
  - Back-to-back throughput is one operation per 4 cycles.
- mul_a/mul_b hold their last operands after completion; they are not cleared.

Test Plan:
1. Single op: req0 A=0x41B26666 (22.3), B=0xBF000000 (-0.5), F_Mul responds -> rsp_id=0, rsp_result=0xC1326666 (-11.15), rsp_err=0, rsp_valid at cycle 3 after handshake, op_count=1.
2. Contention: both valid every cycle after reset with distinct operands -> grants alternate 0,1,0,1. Exactly one ready per handshake cycle, and each requester's own product is returned with the matching rsp_id.
3. Special values: A=0x7F800000 (+inf), B=0x404CCCCC (3.2) -> rsp_inf=1. A=0x00000000, B=3.2 -> rsp_zero=1, rsp_result=0x00000000.
4. Backpressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp fields stable, req ready stays 0, busy=1. Release -> returns to IDLE and op_count increments once.
5. Timeout: a stub holds mul_flag=0 with TIMEOUT=8 -> RESP entered after 8 WAIT cycles with rsp_err=1, rsp_result=0x7FC00000. A flag forced on the same cycle as the timeout gives rsp_err=0.
6. Reset mid-WAIT: assert RST asynchronously -> outputs 0 immediately, no response. After release, a fresh req0 is granted first.
